fir_sample_packer: RTL and testbench

FIR_SAMPLE_PACKER -- requirements
Module: fir_sample_packer

---
 rtl/fir_sample_packer.sv | 142 ++++++++++++++
 tb/tb_fir_sample_packer.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_sample_packer.sv
// Packs decimated 14-bit FIR samples in pairs into 32-bit AXI-Stream words through a FWFT FIFO.
// Optional macro FIR_SAMPLE_PACKER_DROP_CNT_EN adds a saturating dropped-word counter port.
module fir_sample_packer #(
    parameter int FIFO_DEPTH  = 16,
    parameter int FRAME_WORDS = 256
) (
    input  logic        clk,
    input  logic        rstn,
    input  logic        ce,
    input  logic [13:0] is14_sample,
    input  logic        i_enable,
    input  logic [7:0]  iu8_decim,
    input  logic        i_ovf_clr,
    output logic [31:0] m_axis_tdata,
    output logic        m_axis_tvalid,
    input  logic        m_axis_tready,
    output logic        m_axis_tlast,
`ifdef FIR_SAMPLE_PACKER_DROP_CNT_EN
    output logic [15:0] ou16_drop_count,
`endif
    output logic        o_overflow
);

    localparam int AW = $clog2(FIFO_DEPTH);

    logic [7:0]  dcnt;
    logic [7:0]  dlen;
    logic [7:0]  n_in;
    logic        phase;
    logic [15:0] lower;
    logic [15:0] sample_ext;
    logic [31:0] word_q;
    logic        push_q;

    assign n_in       = (iu8_decim == 8'd0) ? 8'd1 : iu8_decim;
    assign sample_ext = {{2{is14_sample[13]}}, is14_sample};

    // The ratio is latched whenever the counter sits at 0, so a new N only applies after a wrap.
    always_ff @(posedge clk) begin
        if (!rstn) begin
            dcnt   <= 8'd0;
            dlen   <= 8'd1;
            phase  <= 1'b0;
            lower  <= 16'd0;
            word_q <= 32'd0;
            push_q <= 1'b0;
        end else begin
            push_q <= 1'b0;
            if (!i_enable) begin
                dcnt  <= 8'd0;
                phase <= 1'b0;
                lower <= 16'd0;
            end else if (ce) begin
                if (dcnt == 8'd0) begin
                    dlen <= n_in;
                    dcnt <= (n_in == 8'd1) ? 8'd0 : 8'd1;
                    if (!phase) begin
                        lower <= sample_ext;
                        phase <= 1'b1;
                    end else begin
                        word_q <= {sample_ext, lower};
                        push_q <= 1'b1;
                        phase  <= 1'b0;
                    end
                end else begin
                    dcnt <= (dcnt == 8'(dlen - 8'd1)) ? 8'd0 : 8'(dcnt + 8'd1);
                end
            end
        end
    end

    // Output handshake: a word moves only on a cycle where m_axis_tvalid and m_axis_tready
    // are both high; while tvalid is high and tready low, tdata/tlast hold the FIFO head.
    logic [32:0] mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr;
    logic [AW:0] rd_ptr;
    logic [AW:0] count;
    logic [15:0] fcnt;
    logic        empty;
    logic        full;
    logic        pop;
    logic        wr_en;
    logic        drop;
    logic        frame_last;
    logic [32:0] head;

    assign count      = wr_ptr - rd_ptr;
    assign empty      = (count == '0);
    assign full       = (count == (AW+1)'(FIFO_DEPTH));
    assign pop        = !empty && m_axis_tready;
    assign wr_en      = push_q && (!full || pop);
    assign drop       = push_q && full && !pop;
    assign frame_last = (fcnt == 16'(FRAME_WORDS - 1));
    assign head       = mem[rd_ptr[AW-1:0]];

    assign m_axis_tvalid = !empty;
    assign m_axis_tdata  = empty ? 32'd0 : head[31:0];
    assign m_axis_tlast  = !empty && head[32];

    always_ff @(posedge clk) begin
        if (wr_en) begin
            mem[wr_ptr[AW-1:0]] <= {frame_last, word_q};
        end
    end

    always_ff @(posedge clk) begin
        if (!rstn) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            fcnt       <= 16'd0;
            o_overflow <= 1'b0;
        end else begin
            if (pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr_en) begin
                wr_ptr <= wr_ptr + 1'b1;
                fcnt   <= frame_last ? 16'd0 : 16'(fcnt + 16'd1);
            end
            if (drop) begin
                o_overflow <= 1'b1;
            end else if (i_ovf_clr) begin
                o_overflow <= 1'b0;
            end
        end
    end

`ifdef FIR_SAMPLE_PACKER_DROP_CNT_EN
    always_ff @(posedge clk) begin
        if (!rstn) begin
            ou16_drop_count <= 16'd0;
        end else if (drop) begin
            if (ou16_drop_count != 16'hFFFF) begin
                ou16_drop_count <= ou16_drop_count + 16'd1;
            end
        end else if (i_ovf_clr) begin
            ou16_drop_count <= 16'd0;
        end
    end
`endif

endmodule

// File: tb/tb_fir_sample_packer.sv
// Randomized and directed bench for fir_sample_packer against a queue-based behavioural model.
module tb_fir_sample_packer;

    localparam int DEPTH = 4;
    localparam int FRAME = 3;

    logic        clk = 1'b0;
    logic        rstn;
    logic        ce;
    logic [13:0] is14_sample;
    logic        i_enable;
    logic [7:0]  iu8_decim;
    logic        i_ovf_clr;
    logic [31:0] m_axis_tdata;
    logic        m_axis_tvalid;
    logic        m_axis_tready;
    logic        m_axis_tlast;
    logic        o_overflow;
`ifdef FIR_SAMPLE_PACKER_DROP_CNT_EN
    logic [15:0] ou16_drop_count;
`endif

    fir_sample_packer #(.FIFO_DEPTH(DEPTH), .FRAME_WORDS(FRAME)) dut (
        .clk           (clk),
        .rstn          (rstn),
        .ce            (ce),
        .is14_sample   (is14_sample),
        .i_enable      (i_enable),
        .iu8_decim     (iu8_decim),
        .i_ovf_clr     (i_ovf_clr),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
`ifdef FIR_SAMPLE_PACKER_DROP_CNT_EN
        .ou16_drop_count (ou16_drop_count),
`endif
        .o_overflow    (o_overflow)
    );

    always #5 clk = ~clk;

    // Reference model: accepted half-words queue up, pairs become a pending word,
    // and the pending word enters a bounded word queue one cycle later.
    logic [32:0] exp_q[$];
    logic [15:0] half_q[$];
    logic [32:0] got_q[$];
    int          m_idx;
    int          m_n;
    logic        m_pend;
    logic [31:0] m_pend_word;
    int          m_fidx;
    logic        m_ovf;
    int          m_drops;
    int          n_checks = 0;
    int          n_fail   = 0;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, obs, exp, $time);
        end
    endtask

    task automatic model_edge();
        logic pop;
        logic drop;
        logic last;
        if (!rstn) begin
            exp_q.delete();
            half_q.delete();
            m_idx   = 0;
            m_n     = 1;
            m_pend  = 1'b0;
            m_fidx  = 0;
            m_ovf   = 1'b0;
            m_drops = 0;
        end else begin
            pop  = (exp_q.size() > 0) && m_axis_tready;
            drop = 1'b0;
            if (pop) void'(exp_q.pop_front());
            if (m_pend) begin
                if (exp_q.size() < DEPTH) begin
                    last = (m_fidx + 1 == FRAME);
                    exp_q.push_back({last, m_pend_word});
                    m_fidx = last ? 0 : m_fidx + 1;
                end else begin
                    drop = 1'b1;
                end
            end
            m_pend = 1'b0;
            if (drop) begin
                m_ovf = 1'b1;
                if (m_drops < 65535) m_drops++;
            end else if (i_ovf_clr) begin
                m_ovf   = 1'b0;
                m_drops = 0;
            end
            if (!i_enable) begin
                m_idx = 0;
                half_q.delete();
            end else if (ce) begin
                if (m_idx == 0) begin
                    m_n = (iu8_decim == 8'd0) ? 1 : int'(iu8_decim);
                    half_q.push_back({{2{is14_sample[13]}}, is14_sample});
                end
                m_idx = (m_idx + 1) % m_n;
                if (half_q.size() == 2) begin
                    m_pend      = 1'b1;
                    m_pend_word = {half_q[1], half_q[0]};
                    half_q.delete();
                end
            end
        end
    endtask

    task automatic compare_all();
        check_eq("tvalid", 32'(m_axis_tvalid), 32'(exp_q.size() > 0));
        if (exp_q.size() > 0) begin
            check_eq("tdata", m_axis_tdata, exp_q[0][31:0]);
            check_eq("tlast", 32'(m_axis_tlast), 32'(exp_q[0][32]));
        end else begin
            check_eq("tdata_idle", m_axis_tdata, 32'd0);
            check_eq("tlast_idle", 32'(m_axis_tlast), 32'd0);
        end
        check_eq("overflow", 32'(o_overflow), 32'(m_ovf));
`ifdef FIR_SAMPLE_PACKER_DROP_CNT_EN
        check_eq("drop_count", 32'(ou16_drop_count), 32'(m_drops));
`endif
    endtask

    // Called at a falling edge with inputs already driven; advances one clock.
    task automatic step();
        if (rstn && m_axis_tvalid && m_axis_tready) got_q.push_back({m_axis_tlast, m_axis_tdata});
        model_edge();
        @(posedge clk);
        #1;
        compare_all();
        @(negedge clk);
    endtask

    task automatic feed(input logic [13:0] s);
        ce          = 1'b1;
        is14_sample = s;
        step();
        ce          = 1'b0;
    endtask

    task automatic do_reset();
        rstn = 1'b0;
        ce   = 1'b0;
        step();
        step();
        rstn = 1'b1;
        got_q.delete();
    endtask

    initial begin
        rstn = 1'b0; ce = 1'b0; is14_sample = '0; i_enable = 1'b0;
        iu8_decim = 8'd1; i_ovf_clr = 1'b0; m_axis_tready = 1'b0;
        @(negedge clk);

        // Reset state
        do_reset();
        check_eq("rst_tvalid", 32'(m_axis_tvalid), 32'd0);
        check_eq("rst_tdata", m_axis_tdata, 32'd0);
        check_eq("rst_tlast", 32'(m_axis_tlast), 32'd0);
        check_eq("rst_overflow", 32'(o_overflow), 32'd0);

        // Basic packing and latency
        i_enable = 1'b1; iu8_decim = 8'd1; m_axis_tready = 1'b1;
        feed(14'h1FFF);
        feed(14'h2000);
        check_eq("pack_lat1_tvalid", 32'(m_axis_tvalid), 32'd0);
        step();
        check_eq("pack_lat2_tvalid", 32'(m_axis_tvalid), 32'd1);
        check_eq("pack_word", m_axis_tdata, 32'hE0001FFF);
        repeat (3) step();

        // Decimation by 4
        do_reset();
        i_enable = 1'b1; iu8_decim = 8'd4; m_axis_tready = 1'b1;
        for (int i = 0; i < 16; i++) feed(14'(i));
        repeat (4) step();
        check_eq("decim_count", 32'(got_q.size()), 32'd2);
        if (got_q.size() >= 2) begin
            check_eq("decim_w0", got_q[0][31:0], 32'h00040000);
            check_eq("decim_w1", got_q[1][31:0], 32'h000C0008);
        end

        // Framing with FRAME_WORDS=3
        do_reset();
        i_enable = 1'b1; iu8_decim = 8'd1; m_axis_tready = 1'b1;
        for (int i = 0; i < 16; i++) feed(14'($urandom_range(0, 16383)));
        repeat (4) step();
        check_eq("frame_count", 32'(got_q.size()), 32'd8);
        for (int k = 0; k < 8 && k < got_q.size(); k++)
            check_eq($sformatf("frame_tlast%0d", k), 32'(got_q[k][32]), 32'((k == 2) || (k == 5)));

        // Overflow with tready held low
        do_reset();
        i_enable = 1'b1; iu8_decim = 8'd1; m_axis_tready = 1'b0;
        for (int i = 0; i < 12; i++) feed(14'(i));
        step();
        check_eq("ovf_flag", 32'(o_overflow), 32'd1);
`ifdef FIR_SAMPLE_PACKER_DROP_CNT_EN
        check_eq("ovf_drops", 32'(ou16_drop_count), 32'd2);
`endif
        m_axis_tready = 1'b1;
        repeat (6) step();
        check_eq("ovf_held", 32'(got_q.size()), 32'd4);
        if (got_q.size() >= 4) begin
            check_eq("ovf_w0", got_q[0][31:0], 32'h00010000);
            check_eq("ovf_w1", got_q[1][31:0], 32'h00030002);
            check_eq("ovf_w2", got_q[2][31:0], 32'h00050004);
            check_eq("ovf_w3", got_q[3][31:0], 32'h00070006);
        end
        i_ovf_clr = 1'b1;
        step();
        i_ovf_clr = 1'b0;
        check_eq("ovf_cleared", 32'(o_overflow), 32'd0);

        // Full FIFO with push and pop on the same edge
        do_reset();
        i_enable = 1'b1; iu8_decim = 8'd1; m_axis_tready = 1'b0;
        for (int i = 0; i < 8; i++) feed(14'(i));
        repeat (2) step();
        feed(14'h0100);
        feed(14'h0200);
        m_axis_tready = 1'b1;
        step();
        m_axis_tready = 1'b0;
        check_eq("fullpop_ovf", 32'(o_overflow), 32'd0);
        got_q.delete();
        m_axis_tready = 1'b1;
        repeat (6) step();
        check_eq("fullpop_count", 32'(got_q.size()), 32'd4);
        if (got_q.size() >= 4) check_eq("fullpop_last", got_q[3][31:0], 32'h02000100);

        // Enable toggled after one accepted sample
        do_reset();
        i_enable = 1'b1; iu8_decim = 8'd1; m_axis_tready = 1'b1;
        feed(14'd9);
        i_enable = 1'b0;
        step();
        i_enable = 1'b1;
        step();
        feed(14'd5);
        feed(14'd6);
        repeat (4) step();
        check_eq("enable_count", 32'(got_q.size()), 32'd1);
        if (got_q.size() >= 1) check_eq("enable_word", got_q[0][31:0], 32'h00060005);

        // Reset with words queued and a half word pending
        do_reset();
        i_enable = 1'b1; iu8_decim = 8'd1; m_axis_tready = 1'b0;
        for (int i = 0; i < 7; i++) feed(14'(i + 1));
        step();
        check_eq("midrst_pre_tvalid", 32'(m_axis_tvalid), 32'd1);
        rstn = 1'b0;
        step();
        check_eq("midrst_tvalid", 32'(m_axis_tvalid), 32'd0);
        rstn = 1'b1;
        m_axis_tready = 1'b1;
        repeat (10) step();
        check_eq("midrst_stale", 32'(got_q.size()), 32'd0);

        // Randomized traffic
        do_reset();
        for (int c = 0; c < 3000; c++) begin
            rstn          = ($urandom_range(0, 499) != 0);
            i_enable      = ($urandom_range(0, 19) != 0);
            ce            = ($urandom_range(0, 9) < 6);
            is14_sample   = 14'($urandom_range(0, 16383));
            m_axis_tready = ($urandom_range(0, 1) == 1);
            i_ovf_clr     = ($urandom_range(0, 19) == 0);
            if ($urandom_range(0, 49) == 0) iu8_decim = 8'($urandom_range(0, 3));
            step();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
